// File: rtl/snake_renderer.sv
// Snake/food raster overlay: snapshots segment cells once per frame into shadow
// coordinates, commits them atomically, and colours pixels through a 2-stage pipe.
// Optional macro SNAKE_HEAD_COLOR_EN draws segment 0 in orange instead of yellow.
module snake_renderer #(
    parameter int MAX_LEN   = 16,
    parameter int GRID_COLS = 16,
    parameter int GRID_ROWS = 16,
    parameter int CELL_PX   = 30,
    parameter int H_ORIGIN  = 144,
    parameter int V_ORIGIN  = 35,
    localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Bright,
    input  logic [9:0]             hCount,
    input  logic [9:0]             vCount,
    input  logic                   Frame_Start,
    input  logic                   Qi,
    input  logic                   Qw,
    input  logic                   Ql,
    input  logic                   Qc,
    input  logic [7:0]             Food,
    input  logic [LEN_W-1:0]       Length,
    input  logic [8*MAX_LEN-1:0]   Locations_Flat,
    output logic                   Busy,
    output logic [11:0]            rgb,
    output logic [11:0]            background
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [31:0] P_COLS  = 32'(GRID_COLS);
    localparam logic [31:0] P_CELLS = 32'(GRID_COLS * GRID_ROWS);
    localparam logic [31:0] P_PX    = 32'(CELL_PX);
    localparam logic [31:0] P_HO    = 32'(H_ORIGIN);
    localparam logic [31:0] P_VO    = 32'(V_ORIGIN);
    localparam logic [31:0] P_MAX   = 32'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

    function automatic logic [9:0] cell_x(input logic [7:0] loc);
        return 10'(({24'd0, loc} % P_COLS) * P_PX + P_HO);
    endfunction

    function automatic logic [9:0] cell_y(input logic [7:0] loc);
        return 10'(({24'd0, loc} / P_COLS) * P_PX + P_VO);
    endfunction

    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] org);
        return ({1'b0, pos} >= {1'b0, org}) &&
               ({1'b0, pos} < ({1'b0, org} + 11'(CELL_PX)));
    endfunction

    state_t r_state;
    state_t w_next;

    logic                 w_capture;
    logic                 w_convert;
    logic                 w_commit;
    logic                 w_last;
    logic [LEN_W-1:0]     w_len_sat;
    logic [7:0]           w_loc_arr [MAX_LEN];
    logic [7:0]           w_loc;
    logic                 w_loc_ok;

    logic [8*MAX_LEN-1:0] r_locs;
    logic [LEN_W-1:0]     r_len;
    logic [IDX_W-1:0]     r_idx;
    logic [7:0]           r_food_cap;
    logic                 r_food_pend;

    logic [9:0]           r_sh_x [MAX_LEN];
    logic [9:0]           r_sh_y [MAX_LEN];
    logic [MAX_LEN-1:0]   r_sh_valid;

    logic [9:0]           r_act_x [MAX_LEN];
    logic [9:0]           r_act_y [MAX_LEN];
    logic [MAX_LEN-1:0]   r_act_valid;
    logic [9:0]           r_food_x;
    logic [9:0]           r_food_y;
    logic                 r_food_valid;

    logic [MAX_LEN-1:0]   w_hit;
    logic                 w_food_hit;
    logic [MAX_LEN-1:0]   r_hit;
    logic                 r_food_hit;
    logic                 r_bright_d;
    logic [11:0]          w_pix;
    logic [11:0]          r_rgb;
    logic [11:0]          r_bg;

    assign rgb        = r_rgb;
    assign background = r_bg;

    always_comb begin
        w_len_sat = Length;
        if (32'(Length) > P_MAX) begin
            w_len_sat = LEN_W'(MAX_LEN);
        end
    end

    // Segment 0 sits in the MSBs of the flat bus.
    always_comb begin
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            w_loc_arr[i] = r_locs[8*(MAX_LEN-1-i) +: 8];
        end
    end

    assign w_loc    = w_loc_arr[r_idx];
    assign w_loc_ok = ({24'd0, w_loc} < P_CELLS);
    assign w_last   = (32'(r_idx) + 32'd1) >= 32'(r_len);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Frame_Start) begin
                    w_next = (w_len_sat == '0) ? S_COMMIT : S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (Qi) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy      = 1'b0;
        w_capture = 1'b0;
        w_convert = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            S_IDLE:    w_capture = Frame_Start;
            S_CONVERT: begin
                Busy      = 1'b1;
                w_convert = !Qi;
            end
            S_COMMIT: begin
                Busy     = 1'b1;
                w_commit = 1'b1;
            end
            default: ;
        endcase
    end

    // Shadow mask is cleared at capture so segments beyond the new length stay hidden.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_food_pend <= 1'b0;
            r_sh_valid  <= '0;
        end else if (w_capture) begin
            r_len       <= w_len_sat;
            r_idx       <= '0;
            r_food_pend <= Qc;
            r_sh_valid  <= '0;
        end else if (w_convert) begin
            r_idx             <= r_idx + 1'b1;
            r_sh_valid[r_idx] <= w_loc_ok;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_capture) begin
            r_locs <= Locations_Flat;
            if (Qc) begin
                r_food_cap <= Food;
            end
        end
        if (w_convert) begin
            r_sh_x[r_idx] <= cell_x(w_loc);
            r_sh_y[r_idx] <= cell_y(w_loc);
        end
        if (w_commit) begin
            r_act_x <= r_sh_x;
            r_act_y <= r_sh_y;
            if (r_food_pend) begin
                r_food_x <= cell_x(r_food_cap);
                r_food_y <= cell_y(r_food_cap);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_act_valid  <= '0;
            r_food_valid <= 1'b0;
        end else if (Qi) begin
            r_act_valid  <= '0;
            r_food_valid <= 1'b0;
        end else if (w_commit) begin
            r_act_valid <= r_sh_valid;
            if (r_food_pend) begin
                r_food_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            w_hit[i] = r_act_valid[i] && in_span(hCount, r_act_x[i]) &&
                       in_span(vCount, r_act_y[i]);
        end
    end

    assign w_food_hit = r_food_valid && in_span(hCount, r_food_x) &&
                        in_span(vCount, r_food_y);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hit      <= '0;
            r_food_hit <= 1'b0;
            r_bright_d <= 1'b0;
        end else begin
            r_hit      <= w_hit;
            r_food_hit <= w_food_hit;
            r_bright_d <= Bright;
        end
    end

    always_comb begin
        w_pix = r_bg;
        if (!r_bright_d) begin
            w_pix = 12'h000;
        end
`ifdef SNAKE_HEAD_COLOR_EN
        else if (r_hit[0]) begin
            w_pix = 12'hF80;
        end
`endif
        else if (|r_hit) begin
            w_pix = 12'hFF0;
        end else if (r_food_hit) begin
            w_pix = 12'hFFF;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rgb <= 12'h000;
            r_bg  <= 12'h000;
        end else begin
            r_rgb <= w_pix;
            if (Qi) begin
                r_bg <= 12'h000;
            end else if (Ql) begin
                r_bg <= 12'hF00;
            end else if (Qw) begin
                r_bg <= 12'h0F0;
            end else begin
                r_bg <= 12'h000;
            end
        end
    end

endmodule

// File: tb/tb_snake_renderer.sv
// Directed bench for snake_renderer: default grid plus a 16x8 grid instance
// sharing all inputs; expected colours are hand-computed cell geometry.
module tb_snake_renderer;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
`ifdef SNAKE_HEAD_COLOR_EN
    localparam logic [11:0] HEAD = 12'hF80;
`else
    localparam logic [11:0] HEAD = 12'hFF0;
`endif

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        b;
        logic [11:0] exp;
        logic [11:0] exp8;
    } pix_vec_t;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 Bright;
    logic [9:0]           hCount;
    logic [9:0]           vCount;
    logic                 Frame_Start;
    logic                 Qi, Qw, Ql, Qc;
    logic [7:0]           Food;
    logic [LEN_W-1:0]     Length;
    logic [8*MAX_LEN-1:0] Locations_Flat;
    logic                 Busy, Busy8;
    logic [11:0]          rgb, rgb8, background, background8;

    logic [7:0] segs [MAX_LEN];
    int n_vec = 0;
    int n_err = 0;

    pix_vec_t t1 [6];
    pix_vec_t t2 [12];
    pix_vec_t t3 [4];
    pix_vec_t t5 [3];
    pix_vec_t t6 [2];

    snake_renderer #(.MAX_LEN(16), .GRID_COLS(16), .GRID_ROWS(16)) u_dut (
        .Clk(Clk), .Reset(Reset), .Bright(Bright), .hCount(hCount), .vCount(vCount),
        .Frame_Start(Frame_Start), .Qi(Qi), .Qw(Qw), .Ql(Ql), .Qc(Qc), .Food(Food),
        .Length(Length), .Locations_Flat(Locations_Flat), .Busy(Busy), .rgb(rgb),
        .background(background)
    );

    snake_renderer #(.MAX_LEN(16), .GRID_COLS(16), .GRID_ROWS(8)) u_dut8 (
        .Clk(Clk), .Reset(Reset), .Bright(Bright), .hCount(hCount), .vCount(vCount),
        .Frame_Start(Frame_Start), .Qi(Qi), .Qw(Qw), .Ql(Ql), .Qc(Qc), .Food(Food),
        .Length(Length), .Locations_Flat(Locations_Flat), .Busy(Busy8), .rgb(rgb8),
        .background(background8)
    );

    always #5 Clk = ~Clk;

    function automatic pix_vec_t pv(input int h, input int v, input bit b,
                                    input logic [11:0] e, input logic [11:0] e8);
        pix_vec_t t;
        t.h = 10'(h);
        t.v = 10'(v);
        t.b = b;
        t.exp = e;
        t.exp8 = e8;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pack_locs();
        for (int i = 0; i < MAX_LEN; i++) begin
            Locations_Flat[8*(MAX_LEN-1-i) +: 8] = segs[i];
        end
    endtask

    task automatic fill_segs(input logic [7:0] v);
        for (int i = 0; i < MAX_LEN; i++) segs[i] = v;
    endtask

    // Holds the pixel for one edge, then blanks it; rgb after the second edge must show it.
    task automatic pix(input string name, input pix_vec_t t);
        hCount = t.h;
        vCount = t.v;
        Bright = t.b;
        @(posedge Clk); #1;
        Bright = 1'b0;
        hCount = '0;
        vCount = '0;
        @(posedge Clk); #1;
        check({name, "_rgb"}, rgb, t.exp);
        check({name, "_rgb8"}, rgb8, t.exp8);
    endtask

    task automatic run_frame(input string name, input int exp_busy, input int inject_at);
        int cnt;
        check({name, "_idle"}, Busy, 0);
        Frame_Start = 1'b1;
        @(posedge Clk); #1;
        Frame_Start = 1'b0;
        cnt = 0;
        while (Busy && cnt < 60) begin
            cnt++;
            if (cnt == inject_at) begin
                Frame_Start = 1'b1;
                Length = 5'd2;
                Locations_Flat = {MAX_LEN{8'h55}};
            end else begin
                Frame_Start = 1'b0;
            end
            @(posedge Clk); #1;
        end
        Frame_Start = 1'b0;
        check({name, "_busy_cycles"}, cnt, exp_busy);
    endtask

    initial begin
        t1[0] = pv(144, 35, 1, HEAD, HEAD);
        t1[1] = pv(173, 64, 1, HEAD, HEAD);
        t1[2] = pv(174, 35, 1, 12'h000, 12'h000);
        t1[3] = pv(144, 65, 1, 12'h000, 12'h000);
        t1[4] = pv(174, 65, 1, 12'h000, 12'h000);
        t1[5] = pv(204, 95, 1, 12'h000, 12'h000);

        t2[0]  = pv(144, 35, 1, HEAD, HEAD);
        t2[1]  = pv(174, 35, 1, 12'hFF0, 12'hFF0);
        t2[2]  = pv(173, 64, 1, HEAD, HEAD);
        t2[3]  = pv(174, 64, 1, 12'hFF0, 12'hFF0);
        t2[4]  = pv(144, 65, 1, 12'h000, 12'h000);
        t2[5]  = pv(174, 65, 1, 12'hFF0, 12'hFF0);
        t2[6]  = pv(203, 94, 1, 12'hFF0, 12'hFF0);
        t2[7]  = pv(204, 95, 1, 12'hFFF, 12'hFFF);
        t2[8]  = pv(233, 124, 1, 12'hFFF, 12'hFFF);
        t2[9]  = pv(234, 95, 1, 12'h000, 12'h000);
        t2[10] = pv(204, 95, 0, 12'h000, 12'h000);
        t2[11] = pv(143, 35, 1, 12'h000, 12'h000);

        t3[0] = pv(594, 485, 1, 12'hFF0, 12'h000);
        t3[1] = pv(144, 35, 1, HEAD, HEAD);
        t3[2] = pv(294, 185, 1, 12'h000, 12'h000);
        t3[3] = pv(204, 95, 1, 12'hFFF, 12'hFFF);

        t5[0] = pv(144, 35, 1, 12'hF00, 12'hF00);
        t5[1] = pv(234, 125, 1, 12'hF00, 12'hF00);
        t5[2] = pv(204, 95, 1, 12'hF00, 12'hF00);

        t6[0] = pv(144, 35, 1, HEAD, HEAD);
        t6[1] = pv(174, 35, 1, 12'hF00, 12'hF00);

        Reset = 1'b1;
        Bright = 1'b0; hCount = '0; vCount = '0; Frame_Start = 1'b0;
        Qi = 1'b0; Qw = 1'b0; Ql = 1'b0; Qc = 1'b0;
        Food = '0; Length = '0; Locations_Flat = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", Busy, 0);
        check("rst_rgb", rgb, 12'h000);
        check("rst_bg", background, 12'h000);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Length 1 with a stale second segment; food offered without Qc.
        fill_segs(8'h00);
        segs[1] = 8'h11;
        pack_locs();
        Length = 5'd1; Food = 8'h22; Qc = 1'b0;
        run_frame("f1", 2, -1);
        for (int i = 0; i < 6; i++) pix($sformatf("p1_%0d", i), t1[i]);

        fill_segs(8'h00);
        segs[0] = 8'h00; segs[1] = 8'h01; segs[2] = 8'h11;
        pack_locs();
        Length = 5'd3; Food = 8'h22; Qc = 1'b1;
        run_frame("f2", 4, -1);
        Qc = 1'b0;
        for (int i = 0; i < 12; i++) pix($sformatf("p2_%0d", i), t2[i]);

        // Saturating length, ignored mid-frame Frame_Start, out-of-grid segment 15.
        fill_segs(8'h00);
        segs[15] = 8'hFF;
        pack_locs();
        Length = 5'd20; Food = 8'h99;
        run_frame("f3", 17, 3);
        for (int i = 0; i < 4; i++) pix($sformatf("p3_%0d", i), t3[i]);

        Ql = 1'b1; Qw = 1'b1;
        @(posedge Clk); #1;
        check("bg_lose_win", background, 12'hF00);
        check("bg8_lose_win", background8, 12'hF00);
        pix("p4_bg", pv(400, 300, 1, 12'hF00, 12'hF00));
        pix("p4_head", pv(144, 35, 1, HEAD, HEAD));
        Qi = 1'b1;
        @(posedge Clk); #1;
        check("bg_init", background, 12'h000);
        Qi = 1'b0; Ql = 1'b0;
        @(posedge Clk); #1;
        check("bg_win", background, 12'h0F0);
        pix("p4_clr_head", pv(144, 35, 1, 12'h0F0, 12'h0F0));
        pix("p4_clr_food", pv(204, 95, 1, 12'h0F0, 12'h0F0));
        pix("p4_clr_seg15", pv(594, 485, 1, 12'h0F0, 12'h0F0));

        fill_segs(8'h00);
        segs[1] = 8'h01; segs[2] = 8'h11;
        pack_locs();
        Length = 5'd3;
        Frame_Start = 1'b1;
        @(posedge Clk); #1;
        Frame_Start = 1'b0;
        check("abort_busy_on", Busy, 1);
        Qi = 1'b1;
        @(posedge Clk); #1;
        Qi = 1'b0;
        check("abort_busy_off", Busy, 0);
        repeat (6) @(posedge Clk);
        #1;
        pix("p4_abort", pv(144, 35, 1, 12'h0F0, 12'h0F0));

        Length = 5'd1;
        run_frame("f4a", 2, -1);
        pix("p4_len1", pv(144, 35, 1, HEAD, HEAD));
        Length = 5'd0;
        run_frame("f4b", 1, -1);
        pix("p4_len0", pv(144, 35, 1, 12'h0F0, 12'h0F0));
        Qw = 1'b0;

        // Reset pulse in the middle of a conversion.
        Ql = 1'b1;
        fill_segs(8'h00);
        pack_locs();
        Length = 5'd1;
        run_frame("f5a", 2, -1);
        fill_segs(8'h33);
        pack_locs();
        Length = 5'd3;
        Frame_Start = 1'b1;
        @(posedge Clk); #1;
        Frame_Start = 1'b0;
        @(posedge Clk); #1;
        check("midrst_busy_pre", Busy, 1);
        Reset = 1'b1;
        #1;
        check("midrst_busy", Busy, 0);
        check("midrst_rgb", rgb, 12'h000);
        check("midrst_bg", background, 12'h000);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("midrst_busy_next", Busy, 0);
        for (int i = 0; i < 3; i++) pix($sformatf("p5_%0d", i), t5[i]);

        fill_segs(8'h00);
        pack_locs();
        Length = 5'd1;
        run_frame("f6", 2, -1);
        for (int i = 0; i < 2; i++) pix($sformatf("p6_%0d", i), t6[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
